// File: rtl/c64_dma_responder.sv
// c64_dma_responder: responder side of the toggle req/ack DMA port.
// Each request toggle becomes one C64 expansion-port bus cycle. The block
// asserts /DMA, waits for a usable phi2-high slot with BA high, then drives
// or samples the bus and toggles the ack on the phi2 fall. It also produces
// phi2tick, a one-clk pulse per synchronized phi2 rising edge.
// Optional feature macro: DMA_HOLD_EN keeps /DMA asserted for up to two
// further phi2 falls after a byte, so back-to-back requests skip HALT.
module c64_dma_responder #(
    parameter int SYNC_STAGES  = 2,
    parameter int DATA_DELAY   = 3,
    parameter int SAMPLE_TICKS = 12
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_d,
    input  logic        dma_rw,
    input  logic        dma_req,
    output logic        dma_ack,
    output logic [7:0]  dma_q,
    output logic        phi2tick,
    input  logic        phi2,
    input  logic        ba,
    output logic        dma_n,
    output logic [15:0] bus_a,
    output logic        bus_a_oe,
    output logic        bus_rw,
    output logic [7:0]  bus_d,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in
);

    localparam logic [7:0] DATA_DELAY_T   = 8'(DATA_DELAY);
    localparam logic [7:0] SAMPLE_TICKS_T = 8'(SAMPLE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_WAIT,
        S_CYCLE,
        S_RELEASE
    } state_t;

    // Reset synchronizer: assertion is immediate, release is aligned to clk.
    logic [1:0] rst_sync_q;
    logic       rst_n_int;

    // Internal reset: asynchronous assert, two-flop synchronous deassert.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_int = rst_sync_q[1];

    // Synchronizers and phi2 edge / tick tracking.
    logic [SYNC_STAGES-1:0] phi2_sync_q;
    logic [SYNC_STAGES-1:0] ba_sync_q;
    logic                   phi2_s;
    logic                   ba_s;
    logic                   phi2_prev_q;
    logic                   rise;
    logic                   fall;
    logic                   phi2tick_q;
    logic [7:0]             tick_q;
    logic [7:0]             tick_d;

    // Bring the asynchronous phi2 and BA into the clk domain.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            phi2_sync_q <= '0;
            ba_sync_q   <= '0;
        end else begin
            phi2_sync_q <= {phi2_sync_q[SYNC_STAGES-2:0], phi2};
            ba_sync_q   <= {ba_sync_q[SYNC_STAGES-2:0], ba};
        end
    end

    assign phi2_s = phi2_sync_q[SYNC_STAGES-1];
    assign ba_s   = ba_sync_q[SYNC_STAGES-1];
    assign rise   = phi2_s & ~phi2_prev_q;
    assign fall   = ~phi2_s & phi2_prev_q;

    // Tick counter: cleared on rise, counts clks of phi2 high, saturates.
    always_comb begin
        tick_d = tick_q;
        if (rise) begin
            tick_d = 8'h00;
        end else if (phi2_s && (tick_q != 8'hFF)) begin
            tick_d = tick_q + 8'h01;
        end
    end

    // Edge history, phi2tick pulse and tick counter registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            phi2_prev_q <= 1'b0;
            phi2tick_q  <= 1'b0;
            tick_q      <= 8'h00;
        end else begin
            phi2_prev_q <= phi2_s;
            phi2tick_q  <= rise;
            tick_q      <= tick_d;
        end
    end

    // Transfer FSM state and registered bus outputs.
    state_t      state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        rw_q, rw_d;
    logic        sampled_q, sampled_d;
    logic        dma_ack_q, dma_ack_d;
    logic [7:0]  dma_q_q, dma_q_d;
    logic        dma_n_q, dma_n_d;
    logic [15:0] bus_a_q, bus_a_d;
    logic        bus_a_oe_q, bus_a_oe_d;
    logic        bus_rw_q, bus_rw_d;
    logic [7:0]  bus_d_q, bus_d_d;
    logic        bus_d_oe_q, bus_d_oe_d;
    logic        pending;
`ifdef DMA_HOLD_EN
    logic        hold_q, hold_d;
`endif

    // A new request exists whenever the toggles differ.
    assign pending = (dma_req != dma_ack_q);

    // Next-state and output logic of the transfer FSM.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        sampled_d  = sampled_q;
        dma_ack_d  = dma_ack_q;
        dma_q_d    = dma_q_q;
        dma_n_d    = dma_n_q;
        bus_a_d    = bus_a_q;
        bus_a_oe_d = bus_a_oe_q;
        bus_rw_d   = bus_rw_q;
        bus_d_d    = bus_d_q;
        bus_d_oe_d = bus_d_oe_q;
`ifdef DMA_HOLD_EN
        hold_d     = hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (pending) begin
                    addr_d  = dma_a;
                    wdata_d = dma_d;
                    rw_d    = dma_rw;
                    dma_n_d = 1'b0;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The CPU is only known to be halted after a complete fall.
                if (fall) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Slots where the VIC owns the bus (BA low) are skipped.
                if (rise && ba_s) begin
                    bus_a_oe_d = 1'b1;
                    bus_a_d    = addr_q;
                    bus_rw_d   = ~rw_q;
                    sampled_d  = 1'b0;
                    if (rw_q) begin
                        bus_d_d    = wdata_q;
                        bus_d_oe_d = (tick_d >= DATA_DELAY_T);
                    end
                    state_d = S_CYCLE;
                end
            end
            S_CYCLE: begin
                if (fall) begin
                    // A short high phase never reached the sample tick.
                    if (!rw_q && !sampled_q) begin
                        dma_q_d = bus_d_in;
                    end
                    bus_a_oe_d = 1'b0;
                    bus_d_oe_d = 1'b0;
                    dma_ack_d  = ~dma_ack_q;
`ifdef DMA_HOLD_EN
                    hold_d     = 1'b0;
`endif
                    state_d    = S_RELEASE;
                end else begin
                    if (rw_q && (tick_d >= DATA_DELAY_T)) begin
                        bus_d_oe_d = 1'b1;
                    end
                    if (!rw_q && !sampled_q && (tick_d == SAMPLE_TICKS_T)) begin
                        dma_q_d   = bus_d_in;
                        sampled_d = 1'b1;
                    end
                end
            end
            S_RELEASE: begin
`ifdef DMA_HOLD_EN
                // Keep /DMA low so a follow-on byte can use the next slot.
                if (pending) begin
                    addr_d  = dma_a;
                    wdata_d = dma_d;
                    rw_d    = dma_rw;
                    state_d = S_WAIT;
                end else if (fall) begin
                    if (hold_q) begin
                        dma_n_d = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        hold_d = 1'b1;
                    end
                end
`else
                dma_n_d = 1'b1;
                state_d = S_IDLE;
`endif
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM and output registers; reset drops every enable at once.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            state_q    <= S_IDLE;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            rw_q       <= 1'b0;
            sampled_q  <= 1'b0;
            dma_ack_q  <= 1'b0;
            dma_q_q    <= 8'h00;
            dma_n_q    <= 1'b1;
            bus_a_q    <= 16'h0000;
            bus_a_oe_q <= 1'b0;
            bus_rw_q   <= 1'b1;
            bus_d_q    <= 8'h00;
            bus_d_oe_q <= 1'b0;
`ifdef DMA_HOLD_EN
            hold_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            sampled_q  <= sampled_d;
            dma_ack_q  <= dma_ack_d;
            dma_q_q    <= dma_q_d;
            dma_n_q    <= dma_n_d;
            bus_a_q    <= bus_a_d;
            bus_a_oe_q <= bus_a_oe_d;
            bus_rw_q   <= bus_rw_d;
            bus_d_q    <= bus_d_d;
            bus_d_oe_q <= bus_d_oe_d;
`ifdef DMA_HOLD_EN
            hold_q     <= hold_d;
`endif
        end
    end

    assign dma_ack  = dma_ack_q;
    assign dma_q    = dma_q_q;
    assign phi2tick = phi2tick_q;
    assign dma_n    = dma_n_q;
    assign bus_a    = bus_a_q;
    assign bus_a_oe = bus_a_oe_q;
    assign bus_rw   = bus_rw_q;
    assign bus_d    = bus_d_q;
    assign bus_d_oe = bus_d_oe_q;

endmodule
